axi_4_mst: RTL and testbench
============================

AXI_4_MST -- requirements
Module: axi_4_mst

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter DATA_WIDTH, default 32, AXI data width; strobe width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, stall-cycle limit before the timeout flag sets.
REQ-004 Port M_AXI_ACLK, in, 1, the single clock; one clock, reset is asynchronous and active-low.
REQ-005 Port M_AXI_ARESETN, in, 1, asynchronous active-low reset.
REQ-006 Port cmd_valid / cmd_ready, in / out, 1 / 1, command handshake.
REQ-007 Port cmd_write, in, 1, 1 = write, 0 = read.
REQ-008 Port cmd_addr / cmd_wdata / cmd_wstrb, in, ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8, command payload.
REQ-009 Port rsp_valid / rsp_ready, out / in, 1 / 1, response handshake.
REQ-010 Port rsp_rdata / rsp_resp / rsp_write, out, DATA_WIDTH / 2 / 1, read data, AXI response code, echo of cmd_write.
REQ-011 Port timeout, out, 1, sticky stall flag.
REQ-012 AW channel: M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWADDR out ADDR_WIDTH, M_AXI_AWPROT out 3.
REQ-013 W channel: M_AXI_WVALID out 1, M_AXI_WREADY in 1, M_AXI_WDATA out DATA_WIDTH, M_AXI_WSTRB out DATA_WIDTH/8.
REQ-014 B channel: M_AXI_BVALID in 1, M_AXI_BREADY out 1, M_AXI_BRESP in 2.
REQ-015 AR channel: M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, M_AXI_ARADDR out ADDR_WIDTH, M_AXI_ARPROT out 3.
REQ-016 R channel: M_AXI_RVALID in 1, M_AXI_RREADY out 1, M_AXI_RDATA in DATA_WIDTH, M_AXI_RRESP in 2.

Function
REQ-017 States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP; one transaction at a time.
REQ-018 cmd_ready SHALL be 1 only in IDLE; command is accepted on cmd_valid && cmd_ready.
REQ-019 On accept, addr (bits [1:0] forced 0), wdata, wstrb, write flag SHALL be registered; next state WR if write else RD_ADDR.
REQ-020 AWVALID and WVALID SHALL both rise the cycle after accept; each drops the cycle after its own handshake, independently, in any order or together.
REQ-021 WR SHALL exit to WR_RESP only once both AW and W handshakes have completed.
REQ-022 BREADY SHALL be 1 in WR_RESP only; on BVALID capture BRESP, rsp_rdata <= 0, go RSP.
REQ-023 ARVALID SHALL be 1 in RD_ADDR; on ARREADY go RD_DATA; RREADY 1 in RD_DATA only; on RVALID capture RDATA/RRESP, go RSP.
REQ-024 A VALID SHALL never drop before its handshake; ADDR/DATA/STRB SHALL be stable while VALID is high; AWPROT = ARPROT = 3'b000.
REQ-025 rsp_valid SHALL be 1 in RSP and hold with stable payload until rsp_ready; then IDLE; rsp_resp passes SLVERR/DECERR unmodified.
REQ-026 Stall counter SHALL count cycles spent in WR, WR_RESP, RD_ADDR, RD_DATA, clear on entry to RSP, saturate at TIMEOUT_CYCLES; reaching it sets timeout (sticky until reset); the transaction keeps waiting.
REQ-027 Minimum latency: accept at cycle N, zero-wait slave -> rsp_valid at N+3.

Reset
REQ-028 Asynchronous assertion SHALL force: state IDLE, all AXI VALID/READY outputs 0, rsp_valid 0, cmd_ready 0, timeout 0, payload registers 0; reset mid-transaction abandons it.
REQ-029 First cycle after deassertion: cmd_ready 1.

Verification
REQ-030 Write 0xDEADBEEF, strb 0xF, addr 0x8, slave zero-wait -> AWADDR 0x8, WDATA 0xDEADBEEF, rsp_resp 2'b00, rsp_write 1, rsp_valid at N+3.
REQ-031 Read addr 0x4, slave returns 0x12345678 -> rsp_rdata 0x12345678, rsp_resp 00, rsp_write 0.
REQ-032 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, single B accepted.
REQ-033 rsp_ready low 5 cycles -> rsp_valid and payload held, cmd_ready 0 throughout.
REQ-034 TIMEOUT_CYCLES=8, ARREADY never asserted -> timeout 1 after 8 stall cycles, ARVALID still 1; reset -> all outputs 0.
REQ-035 Slave BRESP 2'b10 -> rsp_resp 2'b10.

Source files
------------

// File: rtl/axi_4_mst_if.sv
// Bundle of the command/response port and the AXI4-Lite master channels.
// The master modport is the view of axi_4_mst; the slave modport is the view of
// whatever sits on the other side (command source, response sink and AXI slave).
interface axi_4_mst_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  // Command / response side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [StrbWidth-1:0]  cmd_wstrb;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_write;
  logic                  timeout;

  // AXI write address / data / response
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]            M_AXI_AWPROT;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [StrbWidth-1:0]  M_AXI_WSTRB;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [1:0]            M_AXI_BRESP;

  // AXI read address / data
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]            M_AXI_ARPROT;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_write, timeout,
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_AWREADY,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_WREADY,
    input  M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_ARREADY,
    input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_write, timeout,
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_AWREADY,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_WREADY,
    output M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_ARREADY,
    output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_4_mst.sv
// Single-outstanding AXI4-Lite master. Takes one command (read or write), runs it
// on the AXI channels and returns the response; a sticky flag reports transactions
// that have been stalled for TIMEOUT_CYCLES cycles.
module axi_4_mst #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic         M_AXI_ACLK,
  input logic         M_AXI_ARESETN,
  axi_4_mst_if.master bus
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0]       CntMax   = CntW'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;

  logic                  stall;
  logic [CntW-1:0]       cnt_d;
  logic [CntW-1:0]       cnt_q;
  logic                  timeout_d;
  logic                  timeout_q;

  // Transaction FSM; every handshake output is a register so it is glitch-free.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= bus.cmd_addr & AddrMask;
            wdata_q     <= bus.cmd_wdata;
            wstrb_q     <= bus.cmd_wstrb;
            write_q     <= bus.cmd_write;
            if (bus.cmd_write) begin
              state_q   <= StWr;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= StRdAddr;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWr: begin
          // AW and W complete independently; leave only when both are done.
          if (awvalid_q && bus.M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && bus.M_AXI_WREADY) wvalid_q <= 1'b0;
          if ((!awvalid_q || bus.M_AXI_AWREADY) && (!wvalid_q || bus.M_AXI_WREADY)) begin
            state_q  <= StWrResp;
            bready_q <= 1'b1;
          end
        end
        StWrResp: begin
          if (bus.M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            resp_q      <= bus.M_AXI_BRESP;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRdAddr: begin
          if (bus.M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (bus.M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rdata_q     <= bus.M_AXI_RDATA;
            resp_q      <= bus.M_AXI_RRESP;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall = (state_q == StWr) || (state_q == StWrResp) ||
                 (state_q == StRdAddr) || (state_q == StRdData);

  // Stall counter saturates; it is zero whenever no AXI transfer is pending.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (stall) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      if (cnt_d == CntMax) timeout_d = 1'b1;
    end
  end

  // Stall counter and sticky timeout flag.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_resp      = resp_q;
  assign bus.rsp_write     = write_q;
  assign bus.timeout       = timeout_q;

  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_4_mst.sv
// Bench for axi_4_mst: directed commands, a scripted AXI slave and a response
// scoreboard. Everything is driven and sampled on the falling clock edge.
module tb_axi_4_mst;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_4_mst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_4_mst #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          write;
    int            acc_cyc;
    int            lat;
  } exp_t;
  exp_t sb_q[$];

  // Slave configuration and statistics
  int            aw_delay = 0;
  int            w_delay = 0;
  bit            ar_never = 0;
  logic [1:0]    cfg_bresp = 2'b00;
  logic [1:0]    cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [SW-1:0] exp_wstrb = '0;
  int            aw_hi = 0;
  int            w_hi = 0;
  int            b_cnt = 0;
  int            rsp_stall = 0;

  // Scripted AXI slave: readies after a programmable wait, B/R one cycle after
  // the address (and data) handshakes.
  initial begin
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, ar_got;
    int aw_wait, w_wait;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BVALID = 0;  bus.M_AXI_BRESP = 0;
    bus.M_AXI_RVALID = 0;  bus.M_AXI_RDATA = 0;  bus.M_AXI_RRESP = 0;
    {aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, ar_got} = '0;
    aw_wait = 0; w_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
        bus.M_AXI_BVALID = 0;  bus.M_AXI_RVALID = 0;
        {aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, ar_got} = '0;
        aw_wait = 0; w_wait = 0;
      end else begin
        if (aw_fire) aw_got = 1;
        if (w_fire) w_got = 1;
        if (ar_fire) ar_got = 1;
        if (b_fire) bus.M_AXI_BVALID = 0;
        if (r_fire) bus.M_AXI_RVALID = 0;
        if (aw_got && w_got && !bus.M_AXI_BVALID) begin
          bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = cfg_bresp;
          aw_got = 0; w_got = 0;
        end
        if (ar_got && !bus.M_AXI_RVALID) begin
          bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = cfg_rdata; bus.M_AXI_RRESP = cfg_rresp;
          ar_got = 0;
        end
        if (bus.M_AXI_AWVALID) begin
          aw_hi++; bus.M_AXI_AWREADY = (aw_wait >= aw_delay); aw_wait++;
        end else begin
          bus.M_AXI_AWREADY = 0; aw_wait = 0;
        end
        if (bus.M_AXI_WVALID) begin
          w_hi++; bus.M_AXI_WREADY = (w_wait >= w_delay); w_wait++;
        end else begin
          bus.M_AXI_WREADY = 0; w_wait = 0;
        end
        bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && !ar_never;
        aw_fire = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
        w_fire  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
        ar_fire = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
        b_fire  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
        r_fire  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
        if (b_fire) b_cnt++;
        if (aw_fire) begin
          check("awaddr", bus.M_AXI_AWADDR, exp_addr);
          check("awprot", bus.M_AXI_AWPROT, 3'b000);
        end
        if (w_fire) begin
          check("wdata", bus.M_AXI_WDATA, exp_wdata);
          check("wstrb", bus.M_AXI_WSTRB, exp_wstrb);
        end
        if (ar_fire) begin
          check("araddr", bus.M_AXI_ARADDR, exp_addr);
          check("arprot", bus.M_AXI_ARPROT, 3'b000);
        end
      end
    end
  end

  // Response monitor / scoreboard; also drives rsp_ready after rsp_stall cycles.
  initial begin
    int seen;
    logic [DW-1:0] h_rdata;
    logic [1:0] h_resp;
    logic h_write;
    exp_t e;
    seen = 0; h_rdata = '0; h_resp = '0; h_write = 0;
    bus.rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.rsp_valid) begin
        bus.rsp_ready = 0; seen = 0;
      end else begin
        seen++;
        if (seen == 1) begin
          h_rdata = bus.rsp_rdata; h_resp = bus.rsp_resp; h_write = bus.rsp_write;
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid with empty scoreboard, expected none");
          end else if (sb_q[0].lat >= 0) begin
            check("rsp_latency", cyc - sb_q[0].acc_cyc, sb_q[0].lat);
          end
        end else begin
          check("hold_rdata", bus.rsp_rdata, h_rdata);
          check("hold_resp", bus.rsp_resp, h_resp);
          check("hold_write", bus.rsp_write, h_write);
          check("hold_cmd_ready", bus.cmd_ready, 0);
        end
        if (seen > rsp_stall) begin
          bus.rsp_ready = 1;
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_resp", bus.rsp_resp, e.resp);
            check("rsp_write", bus.rsp_write, e.write);
          end
          seen = 0;
        end else begin
          bus.rsp_ready = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_awvalid", bus.M_AXI_AWVALID, 0);
    check("rst_wvalid", bus.M_AXI_WVALID, 0);
    check("rst_bready", bus.M_AXI_BREADY, 0);
    check("rst_arvalid", bus.M_AXI_ARVALID, 0);
    check("rst_rready", bus.M_AXI_RREADY, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_payload", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_write}, 0);
    check("rst_axi_payload", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB}, 0);
  endtask

  // Present one command, wait for it to be accepted, and queue the response.
  // Latency is counted from the falling edge after the accept edge, so a
  // response visible in the third cycle after the accept cycle has lat 2.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input logic [DW-1:0] rdata,
                       input logic [1:0] resp, input int lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_ready_wait: cmd_ready is %b, expected 1", bus.cmd_ready);
    end else begin
      bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
      bus.cmd_wstrb = strb; bus.cmd_valid = 1;
      exp_addr = addr & ~32'h3; exp_wdata = wdata; exp_wstrb = strb;
      @(negedge clk);
      bus.cmd_valid = 0;
      check("cmd_ready_busy", bus.cmd_ready, 0);
      if (push) begin
        e.rdata = rdata; e.resp = resp; e.write = wr; e.acc_cyc = cyc; e.lat = lat;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.cmd_ready !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_idle: %0d responses still pending, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, b0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.cmd_wstrb = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1;
    @(negedge clk);
    check("cmd_ready_after_reset", bus.cmd_ready, 1);

    // Zero-wait write
    a0 = aw_hi; w0 = w_hi; b0 = b_cnt;
    issue(1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 2, 1);
    wait_idle();
    check("wr_aw_cycles", aw_hi - a0, 1);
    check("wr_w_cycles", w_hi - w0, 1);
    check("wr_b_count", b_cnt - b0, 1);

    // Zero-wait read
    cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
    issue(0, 32'h4, 32'h0, 4'h0, 32'h12345678, 2'b00, 2, 1);
    wait_idle();

    // AWREADY three cycles late, WREADY immediate; low address bits dropped
    aw_delay = 3; a0 = aw_hi; w0 = w_hi; b0 = b_cnt;
    issue(1, 32'h13, 32'hCAFEF00D, 4'b0101, 32'h0, 2'b00, -1, 1);
    wait_idle();
    check("awdly_aw_cycles", aw_hi - a0, 4);
    check("awdly_w_cycles", w_hi - w0, 1);
    check("awdly_b_count", b_cnt - b0, 1);
    aw_delay = 0;

    // Response back-pressure with DECERR passed through
    rsp_stall = 5; cfg_rdata = 32'hA5A50F0F; cfg_rresp = 2'b11;
    issue(0, 32'h22, 32'h0, 4'h0, 32'hA5A50F0F, 2'b11, -1, 1);
    wait_idle();
    rsp_stall = 0;

    // W late, AW immediate, SLVERR on B
    w_delay = 2; cfg_bresp = 2'b10; a0 = aw_hi; w0 = w_hi; b0 = b_cnt;
    issue(1, 32'h40, 32'h01020304, 4'b0011, 32'h0, 2'b10, -1, 1);
    wait_idle();
    check("wdly_aw_cycles", aw_hi - a0, 1);
    check("wdly_w_cycles", w_hi - w0, 3);
    check("wdly_b_count", b_cnt - b0, 1);
    w_delay = 0; cfg_bresp = 2'b00;
    check("timeout_clear_before", bus.timeout, 0);

    // ARREADY never comes: timeout after exactly TO stall cycles
    ar_never = 1;
    issue(0, 32'h100, 32'h0, 4'h0, 32'h0, 2'b00, -1, 0);
    repeat (TO - 1) @(negedge clk);
    check("timeout_early", bus.timeout, 0);
    @(negedge clk);
    check("timeout_set", bus.timeout, 1);
    check("timeout_arvalid", bus.M_AXI_ARVALID, 1);
    repeat (3) @(negedge clk);
    check("timeout_sticky", bus.timeout, 1);
    check("timeout_arvalid_held", bus.M_AXI_ARVALID, 1);
    #2 rst_n = 0;
    #1 check_reset_outputs();
    ar_never = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("cmd_ready_after_rerst", bus.cmd_ready, 1);

    // Normal operation after the abandoned transaction
    cfg_rdata = 32'h0BADF00D; cfg_rresp = 2'b00;
    issue(0, 32'h8, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 2, 1);
    wait_idle();
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
